// File: rtl/cla_pkg.sv
// Shared types and constants for the nibble-serial carry-lookahead adder.
package cla_pkg;

  localparam int NIBBLE = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_cla_adder_if.sv
// Operand/result handshake bundle between a producer/consumer and serial_cla_adder.
interface serial_cla_adder_if #(parameter int WIDTH = 16);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, overflow
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, overflow
  );

endinterface

// File: rtl/serial_cla_adder_cla.sv
// 4-bit carry-lookahead adder; all carries are derived from generate/propagate terms.
module CLA_Adder (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] Sum,
  output logic       Cout
);

  logic [3:0] g_s;
  logic [3:0] p_s;
  logic [4:0] c_s;

  assign g_s = A & B;
  assign p_s = A ^ B;

  assign c_s[0] = Cin;
  assign c_s[1] = g_s[0] | (p_s[0] & Cin);
  assign c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & Cin);
  assign c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
                | (p_s[2] & p_s[1] & p_s[0] & Cin);
  assign c_s[4] = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
                | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
                | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & Cin);

  assign Sum  = p_s ^ c_s[3:0];
  assign Cout = c_s[4];

endmodule

// File: rtl/serial_cla_adder.sv
// Nibble-serial adder: one 4-bit CLA slice per clock, LSB nibble first, carry registered between nibbles.
module serial_cla_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  serial_cla_adder_if.slave   bus
);

  localparam int N     = WIDTH / NIBBLE;
  localparam int IDX_W = (N > 2) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_t           state_r;
  logic [IDX_W-1:0] idx_r;
  logic             carry_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             ovf_r;
  logic             in_ready_r;
  logic             out_valid_r;

  logic [WIDTH-1:0] a_shift_s;
  logic [WIDTH-1:0] b_shift_s;
  logic [3:0]       nib_sum_s;
  logic             nib_cout_s;

  // Select the current nibble of each captured operand (shift by idx*4).
  assign a_shift_s = a_r >> {idx_r, 2'b00};
  assign b_shift_s = b_r >> {idx_r, 2'b00};

  CLA_Adder u_cla (
    .A    (a_shift_s[3:0]),
    .B    (b_shift_s[3:0]),
    .Cin  (carry_r),
    .Sum  (nib_sum_s),
    .Cout (nib_cout_s)
  );

  // Control FSM plus datapath registers; every output comes straight from a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      idx_r       <= '0;
      carry_r     <= 1'b0;
      a_r         <= '0;
      b_r         <= '0;
      sum_r       <= '0;
      cout_r      <= 1'b0;
      ovf_r       <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid && in_ready_r) begin
            a_r        <= bus.a;
            b_r        <= bus.b;
            carry_r    <= bus.cin;
            idx_r      <= '0;
            in_ready_r <= 1'b0;
            state_r    <= RUN;
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        RUN: begin
          for (int k = 0; k < N; k++) begin
            if (idx_r == IDX_W'(k)) begin
              sum_r[k*NIBBLE +: NIBBLE] <= nib_sum_s;
            end else begin
              sum_r[k*NIBBLE +: NIBBLE] <= sum_r[k*NIBBLE +: NIBBLE];
            end
          end
          carry_r <= nib_cout_s;
          // The last nibble also settles cout and overflow; idx stays at N-1.
          if (idx_r == LAST_IDX) begin
            cout_r      <= nib_cout_s;
            ovf_r       <= a_r[WIDTH-1] ^ b_r[WIDTH-1] ^ nib_sum_s[3] ^ nib_cout_s;
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            idx_r <= idx_r + IDX_W'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end else begin
            out_valid_r <= 1'b1;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.sum       = sum_r;
  assign bus.cout      = cout_r;
  assign bus.overflow  = ovf_r;

endmodule

// File: doc/serial_cla_adder.md
SERIAL_CLA_ADDER -- requirements
Module: serial_cla_adder

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, giving the operand width in bits; legal values are multiples of 4 and at least 8.
REQ-002 The module SHALL have a single clock and a synchronous, active-high reset.
REQ-003 Ports (name, direction, width, meaning):
 - clk        input   1      clock; all state changes on the rising edge
 - rst        input   1      synchronous active-high reset
 - in_valid   input   1      operand set offered
 - in_ready   output  1      block can accept operands
 - a          input   WIDTH  operand A, unsigned or two's complement
 - b          input   WIDTH  operand B
 - cin        input   1      carry into bit 0
 - out_valid  output  1      result available
 - out_ready  input   1      consumer takes the result
 - sum        output  WIDTH  a + b + cin, modulo 2^WIDTH
 - cout       output  1      carry out of bit WIDTH-1
 - overflow   output  1      two's-complement overflow

Function
REQ-004 The block SHALL compute the sum serially, one 4-bit nibble per clock, LSB nibble first, through a single 4-bit carry-lookahead adder instance; N = WIDTH/4.
REQ-005 FSM states SHALL be IDLE, RUN and DONE.
REQ-006 FSM transitions:
 - IDLE to RUN on in_valid && in_ready.
 - RUN to DONE after exactly N RUN cycles.
 - DONE to IDLE on out_ready.
REQ-007 in_ready SHALL be 1 only in IDLE; in_valid SHALL be ignored in RUN and DONE.
REQ-008 On the accepting edge, a, b and cin SHALL be captured into internal registers, the nibble index SHALL be cleared to 0, and the running carry SHALL be loaded with cin.
REQ-009 In each RUN cycle with index i, the block SHALL add nibble i of the captured A and B plus the running carry, write the 4-bit result into sum nibble i, register the nibble carry-out as the new running carry, and increment i.
REQ-010 out_valid SHALL be asserted exactly N cycles after the accepting edge (4 cycles for WIDTH=16), and SHALL be 1 only in DONE.
REQ-011 In DONE, cout SHALL equal the final running carry.
REQ-012 In DONE, overflow SHALL equal a[MSB] ^ b[MSB] ^ sum[MSB] ^ cout, computed from the captured operands.
REQ-013 sum, cout and overflow SHALL hold stable while out_valid=1 and out_ready=0.
REQ-014 out_ready while not in DONE SHALL have no effect.
REQ-015 After DONE with out_ready=1, the block SHALL spend one cycle in IDLE before it can accept again, so the minimum issue interval is N+2 cycles.
REQ-016 sum, cout and overflow SHALL keep their last values in IDLE until the next accept, and bits not yet written during RUN SHALL hold their previous contents.
REQ-017 The nibble index SHALL never wrap past N-1; the transition to DONE SHALL occur on the edge that processes nibble N-1.

Reset
REQ-018 While rst=1 at a clock edge, the block SHALL enter IDLE and clear the following to 0: sum, cout, overflow, out_valid, nibble index, running carry and captured operands.
REQ-019 In IDLE after reset, in_ready SHALL read 1.
REQ-020 Reset asserted in RUN or DONE SHALL discard the operation in progress with no out_valid pulse, and SHALL take priority over in_valid and out_ready on the same edge.

Structure
REQ-021 Package cla_pkg SHALL hold the FSM state enum (IDLE, RUN, DONE) and the constant NIBBLE = 4.
REQ-022 The existing 4-bit CLA_Adder (ports A, B, Cin, Sum, Cout) SHALL be instantiated once as the only sub-module, with no other arithmetic path.
REQ-023 The carry path SHALL be registered per nibble, with no combinational path from inputs to outputs.

Verification
REQ-024 The bench SHALL use WIDTH=16, with out_ready=1 unless stated otherwise, and SHALL cover these scenarios:
 - a=0x1234, b=0x4321, cin=0 -> out_valid 4 cycles after accept; sum=0x5555, cout=0, overflow=0.
 - a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, overflow=0 (carry ripples through all 4 nibbles).
 - a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, overflow=1.
 - a=0x0000, b=0x0000, cin=1 -> sum=0x0001, cout=0, overflow=0.
 - a=0xA5A5, b=0x5A5A, cin=1, out_ready held 0 for 3 cycles in DONE -> sum=0x0000 and cout=1, stable throughout; in_ready=0 during the hold; in_valid pulses during RUN/DONE ignored.
 - rst pulsed on the 2nd RUN cycle -> next cycle state IDLE, in_ready=1, out_valid=0, sum=0, cout=0; no result ever emitted for that operation.
